// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Turns the byte stream from a UART receiver into single register-file
// writes. A command frame is four bytes: SYNC, ADDR, DATA, CHK, where
// CHK = ADDR ^ DATA. A good frame produces one valid/ready write. Bad
// checksums, inter-byte timeouts and bytes arriving while a write is still
// pending are reported as one-cycle error pulses with a sticky cause code.
// Debug counters track accepted writes (wrapping) and errors (saturating).
//
// Parameters
//   SYNC_BYTE     frame start marker
//   TIMEOUT_CLKS  max idle clocks between bytes inside a frame (2..65535)
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   rx_valid     one-cycle strobe, rx_byte is valid
//   rx_byte      received byte
//   wr_ready     register file accepts the write this cycle
//   wr_en        write request (valid)
//   wr_addr      write address, stable while wr_en=1
//   wr_data      write data, stable while wr_en=1
//   busy         high whenever a frame or write is in progress
//   frame_err    one-cycle pulse per detected error
//   err_code     last error cause: 00 none, 01 timeout, 10 checksum,
//                11 overrun
//   frame_count  accepted writes, wraps
//   err_count    errors, saturates at 8'hFF
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    GET_CHK,
    ISSUE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_OVERRUN  = 2'b11
  } err_e;

  // The idle counter is checked against the value it is about to take, so
  // the error registers on the same edge at which the count would reach
  // TIMEOUT_CLKS-1: the pulse appears TIMEOUT_CLKS-1 cycles after the last
  // accepted byte.
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CLKS - 1);

  state_e      state_q,       state_d;
  logic [15:0] tmo_cnt_q,     tmo_cnt_d;
  logic [7:0]  addr_q,        addr_d;
  logic [7:0]  data_q,        data_d;
  logic [7:0]  wr_addr_q,     wr_addr_d;
  logic [7:0]  wr_data_q,     wr_data_d;
  logic        frame_err_q,   frame_err_d;
  err_e        err_code_q,    err_code_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [7:0]  err_count_q,   err_count_d;

  logic        in_frame;
  logic [15:0] tmo_inc;
  logic        timeout_hit;
  logic        err_hit;
  err_e        err_cause;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: every flop is assigned with <= so all registers update together
  // from values computed in the previous cycle; a blocking = here would let
  // later statements see half-updated state and break simulation/synthesis
  // equivalence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    in_frame    = (state_q == GET_ADDR) || (state_q == GET_DATA) ||
                  (state_q == GET_CHK);
    tmo_inc     = tmo_cnt_q + 16'd1;
    // A byte arriving on the limit cycle takes priority over the timeout.
    timeout_hit = in_frame && !rx_valid && (tmo_inc == TMO_LIMIT);
  end

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_count_d = frame_count_q;
    err_hit       = 1'b0;
    err_cause     = ERR_NONE;

    // The idle counter restarts on every byte and whenever the state is
    // left; outside the byte-collecting states it sits at zero.
    tmo_cnt_d = '0;
    if (in_frame && !rx_valid && !timeout_hit) begin
      tmo_cnt_d = tmo_inc;
    end

    unique case (state_q)
      IDLE: begin
        // Anything other than the marker is line noise and is dropped.
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = GET_ADDR;
        end
      end

      // Inside a frame the marker value is ordinary payload, not a resync.
      GET_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_byte;
          state_d = GET_DATA;
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          data_d  = rx_byte;
          state_d = GET_CHK;
        end
      end

      GET_CHK: begin
        if (rx_valid) begin
          if (rx_byte == (addr_q ^ data_q)) begin
            wr_addr_d = addr_q;
            wr_data_d = data_q;
            state_d   = ISSUE;
          end else begin
            err_hit   = 1'b1;
            err_cause = ERR_CHECKSUM;
            state_d   = IDLE;
          end
        end
      end

      ISSUE: begin
        // wr_en is high for the whole of ISSUE, so wr_ready alone
        // completes the handshake.
        if (wr_ready) begin
          frame_count_d = frame_count_q + 8'd1;
          state_d       = IDLE;
        end
        // No buffering: a byte received while the write is pending is lost,
        // but the pending write itself is unaffected.
        if (rx_valid) begin
          err_hit   = 1'b1;
          err_cause = ERR_OVERRUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      err_hit   = 1'b1;
      err_cause = ERR_TIMEOUT;
      state_d   = IDLE;
    end

    frame_err_d = err_hit;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    if (err_hit) begin
      err_code_d = err_cause;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // wr_en and busy are pure decodes of the registered state, so they clear
  // together with the state on reset and never glitch from inputs.
  always_comb begin
    wr_en = (state_q == ISSUE);
    busy  = (state_q != IDLE);
  end

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Directed bench for uart_cmd_ctrl. A frame-level model (byte queue, idle
// cycle count, pending-write flag) predicts every output and is compared
// with the DUT on each falling edge. Directed sequences add literal
// expectations for write counts, error pulses and timing.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam int         TMO  = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic       wr_ready = 1'b1;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_count;
  logic [7:0] err_count;

  uart_cmd_ctrl #(
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Frame-level model
  // -------------------------------------------------------------------------
  bit         m_in_frame;
  bit         m_pend;
  logic [7:0] m_fb[$];
  int         m_idle;
  logic [7:0] m_wa, m_wd, m_fc, m_ec;
  logic [1:0] m_code;
  bit         m_ferr;

  task automatic model_clear();
    m_in_frame = 0;
    m_pend     = 0;
    m_fb.delete();
    m_idle     = 0;
    m_wa       = 8'h00;
    m_wd       = 8'h00;
    m_fc       = 8'h00;
    m_ec       = 8'h00;
    m_code     = 2'b00;
    m_ferr     = 0;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] rb,
                            input logic rdy);
    bit         err;
    logic [1:0] cause;
    err   = 0;
    cause = 2'b00;
    if (m_pend) begin
      if (rdy) begin
        m_pend = 0;
        m_fc   = m_fc + 8'd1;
      end
      if (rv) begin
        err   = 1;
        cause = 2'b11;
      end
    end else if (!m_in_frame) begin
      if (rv && rb == SYNC) begin
        m_in_frame = 1;
        m_fb.delete();
        m_idle = 0;
      end
    end else if (rv) begin
      m_fb.push_back(rb);
      m_idle = 0;
      if (m_fb.size() == 3) begin
        m_in_frame = 0;
        if ((m_fb[0] ^ m_fb[1]) == m_fb[2]) begin
          m_pend = 1;
          m_wa   = m_fb[0];
          m_wd   = m_fb[1];
        end else begin
          err   = 1;
          cause = 2'b10;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO - 1) begin
        err        = 1;
        cause      = 2'b01;
        m_in_frame = 0;
      end
    end
    m_ferr = err;
    if (err) begin
      m_code = cause;
      if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else model_step(rx_valid, rx_byte, wr_ready);
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle comparison plus observation counters for directed checks
  // -------------------------------------------------------------------------
  int         wr_cycles  = 0;
  int         err_pulses = 0;
  logic [7:0] last_addr  = 8'h00;
  logic [7:0] last_data  = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      check("wr_en",       wr_en,       m_pend);
      check("busy",        busy,        m_in_frame || m_pend);
      check("wr_addr",     wr_addr,     m_wa);
      check("wr_data",     wr_data,     m_wd);
      check("frame_err",   frame_err,   m_ferr);
      check("err_code",    err_code,    m_code);
      check("frame_count", frame_count, m_fc);
      check("err_count",   err_count,   m_ec);
      if (wr_en) begin
        wr_cycles++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (frame_err) err_pulses++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (called just after a falling edge)
  // -------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] c);
    send_byte(SYNC);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  // Assertion is offset from the falling edge so the model and the compare
  // process never race on the same event.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequences
  // -------------------------------------------------------------------------
  int wc0, ep0, n;

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wr_en",  wr_en,       0);
    check("rst_busy",   busy,        0);
    check("rst_addr",   wr_addr,     8'h00);
    check("rst_code",   err_code,    2'b00);
    check("rst_fcount", frame_count, 8'h00);
    check("rst_ecount", err_count,   8'h00);

    // Basic frame, wr_ready tied high: 10 ^ 3C = 2C.
    wc0 = wr_cycles;
    send_frame(8'h10, 8'h3C, 8'h2C);
    repeat (3) @(negedge clk);
    check("t1_wr_cycles", wr_cycles - wc0, 1);
    check("t1_addr",      last_addr,       8'h10);
    check("t1_data",      last_data,       8'h3C);
    check("t1_fcount",    frame_count,     8'h01);
    check("t1_ecount",    err_count,       8'h00);
    check("t1_busy",      busy,            0);

    // Stalled write with a stray byte during the stall.
    do_reset();
    wr_ready = 1'b0;
    wc0 = wr_cycles;
    ep0 = err_pulses;
    send_frame(8'h10, 8'h3C, 8'h2C);   // wr_en cycle 1
    repeat (2) @(negedge clk);         // cycle 3
    send_byte(8'h55);                  // cycle 4
    check("t2_ferr",   frame_err, 1);
    check("t2_code",   err_code,  2'b11);
    check("t2_ecount", err_count, 8'h01);
    check("t2_wr_en",  wr_en,     1);
    @(negedge clk);                    // cycle 5
    @(negedge clk);                    // cycle 6
    wr_ready = 1'b1;
    @(negedge clk);
    check("t2_wr_cycles", wr_cycles - wc0,  6);
    check("t2_pulses",    err_pulses - ep0, 1);
    check("t2_fcount",    frame_count,      8'h01);
    check("t2_wr_done",   wr_en,            0);
    check("t2_addr",      last_addr,        8'h10);

    // Byte coinciding with the handshake: write and overrun both happen.
    send_frame(8'h20, 8'h0F, 8'h2F);
    send_byte(8'h77);
    check("t2b_fcount", frame_count, 8'h02);
    check("t2b_ecount", err_count,   8'h02);
    check("t2b_busy",   busy,        0);
    check("t2b_ferr",   frame_err,   1);

    // Two overruns back to back give two adjacent pulses.
    wr_ready = 1'b0;
    send_frame(8'h30, 8'h01, 8'h31);
    send_byte(8'h01);
    check("t2c_ferr1", frame_err, 1);
    send_byte(8'h02);
    check("t2c_ferr2", frame_err, 1);
    check("t2c_ecount", err_count, 8'h04);
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t2c_fcount", frame_count, 8'h03);

    // Checksum error, then recovery.
    do_reset();
    wc0 = wr_cycles;
    send_frame(8'h10, 8'h3C, 8'hFF);
    check("t3_ferr",   frame_err, 1);
    check("t3_code",   err_code,  2'b10);
    check("t3_ecount", err_count, 8'h01);
    check("t3_busy",   busy,      0);
    @(negedge clk);
    check("t3_pulse_w", frame_err, 0);
    check("t3_no_wr",   wr_cycles - wc0, 0);
    send_frame(8'h01, 8'h02, 8'h03);
    repeat (2) @(negedge clk);
    check("t3_addr",   last_addr,   8'h01);
    check("t3_data",   last_data,   8'h02);
    check("t3_fcount", frame_count, 8'h01);

    // Timeout: pulse exactly TMO-1 = 49 cycles after the last byte.
    do_reset();
    send_byte(SYNC);
    send_byte(8'h10);
    n = 0;
    while (!frame_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_tmo_delay", n,        49);
    check("t4_code",      err_code, 2'b01);
    check("t4_busy",      busy,     0);
    check("t4_ecount",    err_count, 8'h01);

    // Byte landing on the limit cycle wins over the timeout.
    send_byte(SYNC);
    send_byte(8'h10);
    repeat (48) @(negedge clk);
    ep0 = err_pulses;
    send_byte(8'h3C);
    check("t4b_busy",   busy,             1);
    check("t4b_pulses", err_pulses - ep0, 0);
    send_byte(8'h2C);
    repeat (2) @(negedge clk);
    check("t4b_fcount", frame_count, 8'h01);
    check("t4b_data",   last_data,   8'h3C);
    check("t4b_ecount", err_count,   8'h01);

    // IDLE noise, saturation of err_count, wrap of frame_count.
    do_reset();
    ep0 = err_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    @(negedge clk);
    check("t5_noise_pulses", err_pulses - ep0, 0);
    check("t5_noise_ecount", err_count,        8'h00);
    check("t5_noise_busy",   busy,             0);
    for (int i = 0; i < 300; i++) begin
      send_frame(8'(i), 8'h5A, 8'(i) ^ 8'h5A ^ 8'h01);
    end
    check("t5_sat", err_count, 8'hFF);
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), ~8'(i), 8'hFF);
      @(negedge clk);
      if (i == 254) check("t5_fc_ff", frame_count, 8'hFF);
    end
    check("t5_wrap",     frame_count, 8'h00);
    check("t5_sat_hold", err_count,   8'hFF);

    // Reset during GET_DATA.
    do_reset();
    send_byte(SYNC);
    send_byte(8'h10);
    check("t6_mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6a_busy",  busy,  0);
    check("t6a_wr_en", wr_en, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wc0 = wr_cycles;
    repeat (5) @(negedge clk);
    check("t6a_no_wr", wr_cycles - wc0, 0);
    check("t6a_idle",  busy,            0);

    // Reset during a stalled ISSUE, after an error so counters are nonzero.
    send_frame(8'h10, 8'h3C, 8'h00);
    wr_ready = 1'b0;
    send_frame(8'h10, 8'h3C, 8'h2C);
    check("t6b_issue", wr_en,     1);
    check("t6b_ec1",   err_count, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    check("t6b_wr_en",  wr_en,     0);
    check("t6b_busy",   busy,      0);
    check("t6b_addr",   wr_addr,   8'h00);
    check("t6b_data",   wr_data,   8'h00);
    check("t6b_code",   err_code,  2'b00);
    check("t6b_ecount", err_count, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    wc0 = wr_cycles;
    repeat (5) @(negedge clk);
    check("t6b_no_wr", wr_cycles - wc0, 0);
    wr_ready = 1'b1;
    send_frame(8'h44, 8'h55, 8'h11);
    repeat (2) @(negedge clk);
    check("t6c_fcount", frame_count, 8'h01);
    check("t6c_addr",   last_addr,   8'h44);
    check("t6c_data",   last_data,   8'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Sequences the UART receiver byte stream into register-write transactions.
- Takes the receiver's data-valid strobe and byte, and assembles 4-byte command frames: SYNC, ADDR, DATA, CHK.
- Checks each frame and issues a single write on a valid/ready handshake toward the register file.
- Handles inter-byte timeout, checksum errors and overruns, and keeps status counters for debug readout.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 20000, max idle clocks between bytes inside a frame; must be ≥2 and fit in 16 bits.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_valid  input  1  one-cycle strobe, byte available from the UART receiver
- rx_byte  input  8  received byte, valid when rx_valid=1
- wr_ready  input  1  register file accepts the write this cycle
- wr_en  output  1  write request (valid)
- wr_addr  output  8  write address
- wr_data  output  8  write data
- busy  output  1  high in any state except IDLE
- frame_err  output  1  one-cycle pulse on any frame error
- err_code  output  2  last error cause: 00 none, 01 timeout, 10 checksum, 11 overrun; held until the next error
- frame_count  output  8  accepted writes, wraps 8'hFF→8'h00
- err_count  output  8  errors, saturates at 8'hFF

Behaviour:
- Clock and reset: one clock, reset is asynchronous and active-low. All flops clear immediately on reset_n=0.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_err=0, err_code=00, frame_count=0, err_count=0, state=IDLE, timeout counter=0.
- Reset mid-frame or mid-ISSUE abandons the transaction. No write is issued after reset_n releases.
- States: IDLE, GET_ADDR, GET_DATA, GET_CHK, ISSUE.
- IDLE:
  - rx_valid with rx_byte==SYNC_BYTE → GET_ADDR.
  - Any other byte is silently discarded: no error, no count.
- GET_ADDR: rx_valid → latch addr, → GET_DATA.
- GET_DATA: rx_valid → latch data, → GET_CHK.
- GET_CHK: rx_valid → compare rx_byte with (addr XOR data).
  - Match: → ISSUE, drive wr_addr/wr_data from the latched values.
  - Mismatch: frame_err pulse, err_code=10, err_count+1, → IDLE.
- A SYNC_BYTE value received in GET_ADDR/GET_DATA/GET_CHK is treated as ordinary data, not a resync.
- Timeout:
  - Counter runs only in GET_ADDR/GET_DATA/GET_CHK. It clears to 0 on every rx_valid and on entry to each state.
  - If the counter reaches TIMEOUT_CLKS-1 without rx_valid: frame_err pulse, err_code=01, err_count+1, → IDLE.
  - If rx_valid arrives in the same cycle the counter hits its limit, rx_valid wins and no timeout occurs.
- ISSUE:
  - wr_en=1 from the cycle after the CHK byte is accepted (1-cycle latency).
  - wr_addr/wr_data are stable while wr_en=1.
  - Transfer completes on a cycle with wr_en=1 and wr_ready=1. Next cycle: wr_en=0, frame_count+1, → IDLE.
  - Back-to-back: a SYNC arriving the cycle after the transfer is accepted normally.
  - rx_valid during ISSUE: the byte is dropped; frame_err pulse, err_code=11, err_count+1.
  - After an overrun, state stays ISSUE and the pending write still completes.
  - If rx_valid and the wr handshake coincide, both happen: write completes, overrun is flagged, state → IDLE.
- frame_err pulses are exactly one cycle wide. Multiple errors on consecutive cycles produce consecutive pulses.
- err_count holds at 8'hFF once reached. frame_count wraps.
- wr_ready is ignored while wr_en=0.

Test Plan:
- Reset, then bytes A5,10,3C,2C with wr_ready tied 1 → one wr_en cycle with wr_addr=10, wr_data=3C; frame_count=1; err_count=0; busy low afterward.
- Same frame with wr_ready held 0 for 5 cycles → wr_en high 6 cycles with stable addr/data; a stray rx_valid byte 55 mid-stall → frame_err pulse, err_code=11, err_count=1, write still completes, frame_count=1.
- Bytes A5,10,3C,FF → frame_err pulse, err_code=10, err_count=1, no wr_en; then a valid frame A5,01,02,03 → write addr 01 data 02.
- TIMEOUT_CLKS=50: send A5,10, then silence → frame_err exactly 49 cycles after the last rx_valid, err_code=01, state IDLE. Repeat with a byte landing on the limit cycle → no timeout.
- Noise bytes 00,FF,5A in IDLE → no error, no count. Then 300 bad-checksum frames → err_count saturates at FF. Then 256 good frames → frame_count wraps to 00.
- Assert reset_n low during GET_DATA and again during ISSUE with wr_ready=0 → all outputs clear asynchronously; no wr_en after release; the next frame works normally.
